// File: rtl/score_cal_stream.sv
// score_cal_stream
//   Streaming score calculator. Each accepted sample holds a boundary point,
//   an inner ring and an outer ring. The block forms an outer/inner ratio
//   (numerator and denominator both biased so the denominator is never zero),
//   divides it with a bit-serial restoring divider to 8 fractional bits, then
//   scales the quotient by (1 + tanh/256) using a value read from an external
//   tanh LUT.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   point_val  packed samples: slot 0 boundary, slots 1..N_IN inner ring,
//              slots N_IN+1..N_IN+N_OUT outer ring (slot s at [WIDTH*s +: WIDTH])
//   in_valid   point_val holds a sample
//   in_ready   block can take a sample (high only while idle)
//   tanh_addr  LUT address, registered when a sample is accepted
//   tanh_q     LUT data, one cycle after tanh_addr; sampled once per sample
//   score      result, 8 fractional bits
//   out_valid  score/ovf hold a result
//   out_ready  downstream takes the result
//   ovf        result did not fit in OW bits
//   dbg_state  current FSM state (0 IDLE, 1 DIV, 2 MUL, 3 OUT)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until the
// transfer; ready may change freely and never depends on valid in the same
// cycle.
//
// Schedule (cycle k = the clock period following the k-th edge after the
// accepting edge): cycle 0 ring sums and tanh_addr registered; cycle 1 the
// divider is loaded; tanh_q is captured at the end of cycle 1 (visible from
// cycle 2) while QW division steps run through cycle QW+1... the multiply
// follows, and out_valid is high from cycle QW+2.
module score_cal_stream #(
  parameter int WIDTH  = 8,
  parameter int N_OUT  = 4,
  parameter int N_IN   = 4,
  parameter int OFFSET = 50,
  parameter int SAT    = 1,
  localparam int NMAX  = (N_OUT > N_IN) ? N_OUT : N_IN,
  localparam int SW    = WIDTH + $clog2(2 * NMAX + 2),
  localparam int QW    = SW + 8,
  localparam int OW    = WIDTH + 13
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH*(N_OUT+N_IN+1)-1:0] point_val,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [7:0]                     tanh_addr,
  input  logic [9:0]                     tanh_q,
  output logic [OW-1:0]                  score,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           ovf,
  output logic [1:0]                     dbg_state
);

  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_MUL, S_OUT} state_t;

  state_t            state;
  logic [SW-1:0]     ring_o, ring_i;
  logic [WIDTH-1:0]  bnd_r, o_last_r, i_last_r;
  logic [SW-1:0]     den;
  logic [SW-1:0]     rem;
  logic [QW-1:0]     dvd;     // dividend bits shift out the top, quotient bits shift in
  logic [CW-1:0]     cnt;
  logic [9:0]        tq_cap;

  // Sample-side combinational terms (only used on the accepting edge).
  logic [SW-1:0]     sum_o, sum_i, outside, qsh, idx;
  logic [7:0]        addr_c;
  logic [WIDTH-1:0]  bnd_c, o_last_c, i_last_c;

  always_comb begin
    sum_o = '0;
    sum_i = '0;
    for (int k = 1; k < N_OUT; k++)
      sum_o = sum_o + SW'(point_val[WIDTH*(N_IN+k) +: WIDTH]);
    for (int k = 1; k < N_IN; k++)
      sum_i = sum_i + SW'(point_val[WIDTH*k +: WIDTH]);
    bnd_c    = point_val[0 +: WIDTH];
    o_last_c = point_val[WIDTH*(N_IN+N_OUT) +: WIDTH];
    i_last_c = point_val[WIDTH*N_IN +: WIDTH];
    outside  = sum_o + SW'(bnd_c);
    qsh      = outside >> 2;
    // Fold indices above OFFSET back down; equal to OFFSET stays as is.
    idx      = (qsh > SW'(OFFSET)) ? (qsh - SW'(OFFSET)) : qsh;
    addr_c   = 8'(idx);
  end

  // Ratio terms from the registered sums; +1 keeps den non-zero.
  logic [SW-1:0] num_c, den_c;
  always_comb begin
    num_c = (ring_o << 1) + SW'(o_last_r) + SW'(bnd_r) + SW'(1);
    den_c = (ring_i << 1) + SW'(i_last_r) + SW'(bnd_r) + SW'(1);
  end

  // One restoring-division step. rem < den always, so trial fits SW+1 bits.
  logic [SW:0]   trial, diff;
  logic          ge;
  logic [SW-1:0] rem_n;
  logic [QW-1:0] dvd_n;
  always_comb begin
    trial = {rem, dvd[QW-1]};
    diff  = trial - {1'b0, den};
    ge    = (trial >= {1'b0, den});
    rem_n = ge ? SW'(diff) : SW'(trial);
    dvd_n = {dvd[QW-2:0], ge};
  end

  // Scale: P = (Q * (tanh + 256)) >> 8 at full precision.
  logic [QW+10:0] prod;
  logic [QW+2:0]  p_full;
  logic           ovf_c;
  logic [OW-1:0]  score_c;
  always_comb begin
    prod    = (QW+11)'(dvd) * (QW+11)'({1'b0, tq_cap} + 11'd256);
    p_full  = (QW+3)'(prod >> 8);
    ovf_c   = ((p_full >> OW) != '0);
    score_c = (ovf_c && (SAT != 0)) ? {OW{1'b1}} : p_full[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      score     <= '0;
      ovf       <= 1'b0;
      tanh_addr <= '0;
      ring_o    <= '0;
      ring_i    <= '0;
      bnd_r     <= '0;
      o_last_r  <= '0;
      i_last_r  <= '0;
      den       <= '0;
      rem       <= '0;
      dvd       <= '0;
      cnt       <= '0;
      tq_cap    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            ring_o    <= sum_o;
            ring_i    <= sum_i;
            bnd_r     <= bnd_c;
            o_last_r  <= o_last_c;
            i_last_r  <= i_last_c;
            tanh_addr <= addr_c;
            cnt       <= '0;
            in_ready  <= 1'b0;
            state     <= S_DIV;
          end else begin
            in_ready  <= 1'b1;
          end
        end
        S_DIV: begin
          cnt <= cnt + CW'(1);
          if (cnt == '0) begin
            dvd <= {num_c, 8'd0};
            den <= den_c;
            rem <= '0;
          end else begin
            dvd <= dvd_n;
            rem <= rem_n;
            if (cnt == CW'(1))
              tq_cap <= tanh_q;
            if (cnt == CW'(QW))
              state <= S_MUL;
          end
        end
        S_MUL: begin
          score     <= score_c;
          ovf       <= ovf_c;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_score_cal_stream.sv
// Testbench for score_cal_stream (default parameters). Two instances share
// all inputs: dut0 saturates on overflow, dut1 truncates.
module tb_score_cal_stream;

  localparam int PW = 72;
  localparam int OW = 21;

  typedef struct packed {
    logic [OW-1:0] s_sat;
    logic [OW-1:0] s_tr;
    logic          ovf;
    logic [7:0]    addr;
  } exp_t;

  typedef struct {
    logic [PW-1:0] pv;
    logic [9:0]    tq;
    exp_t          e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] point_val = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [9:0]    tanh_q = '0;
  logic          in_ready0, out_valid0, ovf0, in_ready1, out_valid1, ovf1;
  logic [7:0]    tanh_addr0, tanh_addr1;
  logic [OW-1:0] score0, score1;
  logic [1:0]    dbg0, dbg1;

  score_cal_stream #(.SAT(1)) dut0 (
    .clk(clk), .rst(rst), .point_val(point_val), .in_valid(in_valid),
    .in_ready(in_ready0), .tanh_addr(tanh_addr0), .tanh_q(tanh_q),
    .score(score0), .out_valid(out_valid0), .out_ready(out_ready),
    .ovf(ovf0), .dbg_state(dbg0));

  score_cal_stream #(.SAT(0)) dut1 (
    .clk(clk), .rst(rst), .point_val(point_val), .in_valid(in_valid),
    .in_ready(in_ready1), .tanh_addr(tanh_addr1), .tanh_q(tanh_q),
    .score(score1), .out_valid(out_valid1), .out_ready(out_ready),
    .ovf(ovf1), .dbg_state(dbg1));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   cyc = 0;
  int   since = 100;
  int   acc_cyc = 0;
  bit   acc_next = 0;
  bit   addr_pending = 0;
  bit   prev_ov = 0;
  logic [7:0] exp_addr_cur = '0;
  logic [9:0] cur_tq = '0;
  logic [9:0] drv_tq = '0;
  exp_t drv_exp;
  exp_t exp_q[$];
  int   acc_log[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bench reference: direct integer arithmetic for the default parameters.
  function automatic exp_t model(input logic [PW-1:0] pv, input logic [9:0] tq);
    longint b, ro, ri, o4, i4, num, den, qv, idx, qq, p;
    exp_t e;
    b   = longint'(pv[7:0]);
    ri  = longint'(pv[15:8]) + longint'(pv[23:16]) + longint'(pv[31:24]);
    i4  = longint'(pv[39:32]);
    ro  = longint'(pv[47:40]) + longint'(pv[55:48]) + longint'(pv[63:56]);
    o4  = longint'(pv[71:64]);
    num = 2 * ro + o4 + b + 1;
    den = 2 * ri + i4 + b + 1;
    qv  = (ro + b) / 4;
    idx = (qv > 50) ? qv - 50 : qv;
    qq  = (num * 256) / den;
    p   = (qq * (longint'(tq) + 256)) / 256;
    e.ovf   = (p >= 2097152);
    e.s_tr  = p[OW-1:0];
    e.s_sat = e.ovf ? {OW{1'b1}} : p[OW-1:0];
    e.addr  = idx[7:0];
    return e;
  endfunction

  function automatic logic [PW-1:0] mk_pv(input logic [7:0] b,
      input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] i3, input logic [7:0] i4,
      input logic [7:0] o1, input logic [7:0] o2, input logic [7:0] o3, input logic [7:0] o4);
    return {o4, o3, o2, o1, i4, i3, i2, i1, b};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < 9; k++) v.pv[8*k +: 8] = 8'($urandom_range(0, 255));
    v.tq = 10'($urandom_range(0, 1023));
    v.e  = model(v.pv, v.tq);
    return v;
  endfunction

  // ---------------- LUT model: data valid only in cycle 1 after accept ----------------
  always @(posedge clk) begin
    #1;
    cyc++;
    if (acc_next) begin
      since    = 0;
      acc_next = 0;
    end else begin
      since++;
    end
    tanh_q = (since == 1) ? cur_tq : 10'h2A5;
  end

  // ---------------- monitor / scoreboard (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      prev_ov = 0;
    end else begin
      if (addr_pending) begin
        check("tanh_addr", tanh_addr0, exp_addr_cur);
        addr_pending = 0;
      end
      if (out_valid0 && !prev_ov) check("latency", cyc - acc_cyc, 22);
      prev_ov = out_valid0;
      if (out_valid0 && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got score %0d, expected no output (t=%0t)", score0, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_out++;
          check("score_sat", score0, e.s_sat);
          check("score_trunc", score1, e.s_tr);
          check("ovf", ovf0, e.ovf);
          check("ovf_trunc", ovf1, e.ovf);
        end
      end
      if (in_valid && in_ready0) begin
        exp_q.push_back(drv_exp);
        acc_next     = 1;
        cur_tq       = drv_tq;
        acc_cyc      = cyc + 1;
        acc_log.push_back(cyc + 1);
        addr_pending = 1;
        exp_addr_cur = drv_exp.addr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    point_val = v.pv;
    drv_tq    = v.tq;
    drv_exp   = v.e;
  endtask

  task automatic send(input vec_t v);
    bit ok;
    ok = 0;
    drive(v);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready0) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready0, 0);
    check({tag, "_out_valid"}, out_valid0, 0);
    check({tag, "_score"}, score0, 0);
    check({tag, "_ovf"}, ovf0, 0);
    check({tag, "_tanh_addr"}, tanh_addr0, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before 400000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  vec_t tbl[9];

  initial begin
    int held;
    int n0;
    vec_t v;

    tbl[0].pv = mk_pv(0, 0, 0, 0, 0, 0, 0, 0, 0);         tbl[0].tq = 10'd0;
    tbl[0].e  = '{s_sat: 256, s_tr: 256, ovf: 0, addr: 0};
    tbl[1].pv = mk_pv(0, 0, 0, 0, 0, 10, 10, 10, 10);     tbl[1].tq = 10'd128;
    tbl[1].e  = '{s_sat: 27264, s_tr: 27264, ovf: 0, addr: 7};
    tbl[2].pv = mk_pv(0, 0, 0, 0, 0, 255, 255, 255, 255); tbl[2].tq = 10'd1023;
    tbl[2].e  = '{s_sat: 2097151, s_tr: 187142, ovf: 1, addr: 141};
    tbl[3].pv = mk_pv(0, 255, 255, 255, 255, 0, 0, 0, 0); tbl[3].tq = 10'd700;
    tbl[3].e  = '{s_sat: 0, s_tr: 0, ovf: 0, addr: 0};
    tbl[4].pv = mk_pv(200, 0, 0, 0, 0, 0, 0, 0, 0);       tbl[4].tq = 10'd512;
    tbl[4].e  = '{s_sat: 768, s_tr: 768, ovf: 0, addr: 50};
    tbl[5].pv = mk_pv(204, 0, 0, 0, 0, 0, 0, 0, 0);       tbl[5].tq = 10'd0;
    tbl[5].e  = '{s_sat: 256, s_tr: 256, ovf: 0, addr: 1};
    for (int i = 6; i < 9; i++) tbl[i] = rand_vec();

    // Reset: outputs at reset values, in_ready rises on the first edge after release.
    rst = 1'b0;
    #12;
    check_reset_vals("por");
    #11;
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", in_ready0, 1);
    @(posedge clk); #1;

    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i]);
      drain();
    end

    // Idle with out_ready high: no spurious output for a while.
    repeat (30) @(posedge clk);
    #1;

    // Back-to-back: in_valid held, new data driven while each sample is in flight.
    acc_log.delete();
    n0 = n_out;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit ok;
      ok = 0;
      drive(rand_vec());
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (in_ready0) begin ok = 1; break; end
      end
      if (!ok) check("b2b_accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("b2b_results", n_out - n0, 4);
    check("b2b_accepts", acc_log.size(), 4);
    for (int i = 1; i < acc_log.size(); i++)
      check("b2b_period", acc_log[i] - acc_log[i-1], 24);

    // Backpressure: result held for 10 cycles, new sample ignored meanwhile.
    out_ready = 1'b0;
    send(tbl[1]);
    begin
      bit ok;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (out_valid0) begin ok = 1; break; end
      end
      if (!ok) check("bp_valid_timeout", 0, 1);
    end
    held = score0;
    check("bp_score", held, 27264);
    @(posedge clk); #1;
    v = tbl[2];
    drive(v);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_score", score0, held);
      check("bp_hold_valid", out_valid0, 1);
      check("bp_in_ready", in_ready0, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready0, 1);
    check("bp_release_valid", out_valid0, 0);
    @(posedge clk); #1;
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset during division: sample discarded, then a clean sample computes correctly.
    send(tbl[1]);
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_vals("mid");
    exp_q.delete();
    addr_pending = 0;
    @(posedge clk); #3;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("mid_no_output", out_valid0, 0);
    send(tbl[2]);
    drain();
    send(tbl[1]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/score_cal_stream.md
SCORE_CAL_STREAM -- requirements
Module: score_cal_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit width of each point sample.
REQ-002 SHALL have parameter N_OUT, default 4, giving the number of outer-ring points (2..8).
REQ-003 SHALL have parameter N_IN, default 4, giving the number of inner-ring points (2..8).
REQ-004 SHALL have parameter OFFSET, default 50, giving the tanh index offset.
REQ-005 SHALL have parameter SAT, default 1, where 1 clamps the score on overflow and 0 truncates it.
REQ-006 SHALL have derived constants SW = WIDTH+$clog2(2*max(N_OUT,N_IN)+2), QW = SW+8 and OW = WIDTH+13.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port point_val, input, WIDTH*(N_OUT+N_IN+1) bits: slot 0 is boundary, slots 1..N_IN are in_1..in_N_IN, and slots N_IN+1..N_IN+N_OUT are out_1..out_N_OUT.
REQ-010 SHALL have port in_valid, input, 1 bit: point_val is valid.
REQ-011 SHALL have port in_ready, output, 1 bit: the block accepts a sample.
REQ-012 SHALL have port tanh_addr, output, 8 bits: external tanh LUT address.
REQ-013 SHALL have port tanh_q, input, 10 bits: LUT data, valid exactly 1 cycle after tanh_addr is presented.
REQ-014 SHALL have port score, output, OW bits: result with 8 fractional bits.
REQ-015 SHALL have port out_valid, output, 1 bit: score is valid.
REQ-016 SHALL have port out_ready, input, 1 bit: the downstream block accepts score.
REQ-017 SHALL have port ovf, output, 1 bit: the current score overflowed OW bits, valid while out_valid is high.

Function
REQ-018 SHALL implement an FSM with states IDLE, DIV, MUL and OUT; in_ready SHALL be 1 only in IDLE.
REQ-019 SHALL, on in_valid&&in_ready (cycle 0), register ring_o = sum(out_1..out_{N_OUT-1}) and ring_i = sum(in_1..in_{N_IN-1}) in SW bits, then go to DIV.
REQ-020 SHALL register num = 2*ring_o + out_N_OUT + boundary + 1 and den = 2*ring_i + in_N_IN + boundary + 1 in SW bits, so den is never 0.
REQ-021 SHALL compute outside = ring_o + boundary and q = outside>>2; idx = q-OFFSET if q>OFFSET else q; tanh_addr = idx[7:0], registered at the cycle-0 edge.
REQ-022 SHALL capture tanh_q internally in cycle 2 and ignore it in all other cycles.
REQ-023 SHALL, in DIV, perform restoring division of (num<<8) by den at one quotient bit per cycle, MSB first, over QW cycles (cycles 1..QW), yielding the floor quotient Q in QW bits.
REQ-024 SHALL, in MUL (cycle QW+1), compute P = (Q * (tanh_q_captured + 256)) >> 8 at full precision.
REQ-025 SHALL set ovf = 1 when P >= 2^OW; score SHALL then be all-ones if SAT=1, else P[OW-1:0].
REQ-026 SHALL assert out_valid from cycle QW+2 (22 for the defaults) and hold score, ovf and out_valid stable until out_ready.
REQ-027 SHALL, on out_valid&&out_ready, drop out_valid the next cycle and return to IDLE; in_ready SHALL rise in that same next cycle.
REQ-028 SHALL ignore in_valid outside IDLE; point_val SHALL not affect an in-flight computation.
REQ-029 SHALL keep out_valid low while out_ready is held high with no result pending.

Reset
REQ-030 SHALL, when rst=0, asynchronously force state IDLE, in_ready=0, out_valid=0, score=0, ovf=0, tanh_addr=0 and clear all internal sum and divider registers.
REQ-031 SHALL, on rst deassertion, raise in_ready on the first clk edge after release.
REQ-032 SHALL, on reset mid-operation, discard the in-flight sample with no output produced.

Verification
REQ-033 SHALL cover: defaults, all points 0, tanh_q=0 -> tanh_addr=0, score=256, ovf=0, out_valid at cycle 22.
REQ-034 SHALL cover: out_1..out_4=10, all else 0, tanh_q=128 -> tanh_addr=7, Q=18176, score=27264.
REQ-035 SHALL cover: boundary=0, out_*=255, in_*=0, tanh_q=1023 -> tanh_addr=141, P=2284294, ovf=1, score=2097151 with SAT=1 and 187142 with SAT=0.
REQ-036 SHALL cover: out_ready held low 10 cycles after out_valid -> score stable, in_ready=0, a new in_valid ignored; one cycle after release in_ready=1.
REQ-037 SHALL cover: rst pulsed low at cycle 8 of DIV -> outputs are the reset values, no out_valid, and the next sample is computed correctly.
REQ-038 SHALL cover: back-to-back samples with out_ready=1 and in_valid=1 -> one result per 24 cycles with no sample lost.
